// File: rtl/port_arbiter.sv
// port_arbiter: round-robin, wormhole-locked arbiter and flit mux for one router output port.
module port_arbiter #(
  parameter int NUM_IN  = 5,
  parameter int FLIT_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN-1:0]        tail,
  input  logic [NUM_IN*FLIT_W-1:0] in_flit,
  output logic [NUM_IN-1:0]        in_ack,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_flit,
  input  logic                     out_ready,
  output logic [NUM_IN-1:0]        grant,
  output logic                     timeout_err,
  output logic [15:0]              pkt_count
);
  localparam int PW = NUM_IN > 1 ? $clog2(NUM_IN) : 1;
  localparam int SW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [PW-1:0] ptr, owner, pick, idx, nxt;
  logic [SW-1:0] stall;
  logic found, xfer, last;
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NUM_IN);
      if (req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
  // grant is zero outside LOCKED, so masking with it yields the owner's view
  always_comb begin
    out_flit = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (grant[i]) out_flit = out_flit | in_flit[i*FLIT_W +: FLIT_W];
  end
  assign out_valid = |(req & grant);
  assign in_ack    = grant & req & {NUM_IN{out_ready}};
  assign xfer      = out_valid & out_ready;
  assign last      = xfer & |(tail & grant);
  assign nxt       = (owner == PW'(NUM_IN - 1)) ? '0 : owner + 1'b1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      grant       <= '0;
      stall       <= '0;
      timeout_err <= 1'b0;
      pkt_count   <= '0;
    end else begin
      timeout_err <= 1'b0;
      if (state == IDLE) begin
        if (found) begin
          state <= LOCKED;
          owner <= pick;
          grant <= NUM_IN'(1) << pick;
          stall <= '0;
        end
      end else if (xfer) begin
        stall <= '0;
        if (last) begin
          state <= IDLE;
          grant <= '0;
          ptr   <= nxt;
          if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
        end
      end else if (!out_valid) begin
        if (stall == SW'(TIMEOUT - 1)) begin
          state       <= IDLE;
          grant       <= '0;
          ptr         <= nxt;
          timeout_err <= 1'b1;
        end else begin
          stall <= stall + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_port_arbiter.sv
// tb_port_arbiter: random multi-input packet traffic checked by a queue-based scoreboard and a behavioural model.
module tb_port_arbiter;
  localparam int N = 5;
  localparam int W = 32;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req, tail, in_ack, grant;
  logic [N*W-1:0] in_flit;
  logic out_valid, out_ready, timeout_err;
  logic [W-1:0] out_flit;
  logic [15:0] pkt_count;
  int total = 0;
  int bad = 0;
  typedef struct {logic [N-1:0] g; logic v; logic [15:0] c; logic t;} st_t;
  typedef struct {int src; logic [W-1:0] f;} xf_t;
  st_t sq[$];
  xf_t xq[$];
  st_t s;
  xf_t x;
  int rem[N];
  int dead[N];
  logic [W-1:0] fval[N];
  int m_owner, m_ptr, m_stall, m_cnt;
  logic m_te;
  int resets_done = 0;

  port_arbiter #(.NUM_IN(N), .FLIT_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .in_flit(in_flit),
    .in_ack(in_ack), .out_valid(out_valid), .out_flit(out_flit),
    .out_ready(out_ready), .grant(grant), .timeout_err(timeout_err),
    .pkt_count(pkt_count));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_stall = 0;
    m_cnt   = 0;
    m_te    = 1'b0;
  endtask

  // Drive one cycle of stimulus, then predict what the coming clock edge does.
  task automatic step();
    st_t st;
    int j;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (dead[i] > 0) dead[i]--;
      if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 4);
      if (rem[i] > 0 && dead[i] == 0 && $urandom_range(0, 299) == 0)
        dead[i] = ($urandom_range(0, 1) == 1) ? TO + 6 : TO - 1;
      req[i]  = rem[i] > 0 && dead[i] == 0 && $urandom_range(0, 4) != 0;
      tail[i] = rem[i] == 1;
      in_flit[i*W +: W] = fval[i];
    end
    out_ready = $urandom_range(0, 4) != 0;
    st.g = (m_owner >= 0) ? N'(1) << m_owner : '0;
    st.v = m_owner >= 0 && req[m_owner];
    st.c = 16'(m_cnt);
    st.t = m_te;
    sq.push_back(st);
    m_te = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (req[j] && m_owner < 0) m_owner = j;
      end
      m_stall = 0;
    end else if (req[m_owner]) begin
      if (out_ready) begin
        xq.push_back('{m_owner, fval[m_owner]});
        m_stall = 0;
        fval[m_owner] = $urandom;
        rem[m_owner]--;
        if (rem[m_owner] == 0) begin
          m_cnt   = (m_cnt == 65535) ? m_cnt : m_cnt + 1;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end else begin
      m_stall++;
      if (m_stall == TO) begin
        m_te    = 1'b1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (sq.size() > 0) begin
      s = sq.pop_front();
      chk("grant", 64'(grant), 64'(s.g));
      chk("out_valid", 64'(out_valid), 64'(s.v));
      chk("pkt_count", 64'(pkt_count), 64'(s.c));
      chk("timeout_err", 64'(timeout_err), 64'(s.t));
      if (out_valid && out_ready) begin
        if (xq.size() == 0) begin
          chk("unexpected_xfer", 64'(1), 64'(0));
        end else begin
          x = xq.pop_front();
          chk("out_flit", 64'(out_flit), 64'(x.f));
          chk("in_ack", 64'(in_ack), 64'(N'(1) << x.src));
        end
      end else begin
        chk("in_ack_idle", 64'(in_ack), 64'(0));
      end
    end
  end

  initial begin
    rst = 1'b0;
    req = '0;
    tail = '0;
    in_flit = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      rem[i]  = 0;
      dead[i] = 0;
      fval[i] = $urandom;
    end
    model_reset();
    #3;
    chk("reset_grant", 64'(grant), 64'(0));
    chk("reset_valid", 64'(out_valid), 64'(0));
    chk("reset_count", 64'(pkt_count), 64'(0));
    chk("reset_ack", 64'(in_ack), 64'(0));
    chk("reset_timeout", 64'(timeout_err), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      if (c >= 3000 && resets_done == 0 && m_owner >= 0 && pkt_count != 0) begin
        // Abort a live lock with an asynchronous reset between clock edges.
        @(posedge clk);
        #1;
        req = '0;
        rst = 1'b0;
        #1;
        chk("midreset_grant", 64'(grant), 64'(0));
        chk("midreset_valid", 64'(out_valid), 64'(0));
        chk("midreset_count", 64'(pkt_count), 64'(0));
        chk("midreset_ack", 64'(in_ack), 64'(0));
        sq.delete();
        xq.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        resets_done++;
      end
      step();
    end
    @(posedge clk);
    #1;
    req = '0;
    repeat (2) @(negedge clk);
    chk("reset_exercised", 64'(resets_done), 64'(1));
    chk("xfer_queue_drained", 64'(xq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
